gate_truth_checker: RTL and testbench

//  Self-checking stimulus/response stage wrapped around the two-input gate block.

---
 rtl/gate_truth_checker_if.sv | 33 +++
 rtl/gate_truth_checker.sv | 185 ++++++++++++++++++
 tb/tb_gate_truth_checker.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_truth_checker_if.sv
// Bus between the truth-table checker and its environment: run control, the
// a/b stimulus, the seven gate responses and the result/status outputs.
interface gate_truth_checker_if #(
   parameter int ERR_W = 4
);
   logic             start;
   logic             a;
   logic             b;
   logic             and_out;
   logic             or_out;
   logic             not_out;
   logic             nand_out;
   logic             nor_out;
   logic             xor_out;
   logic             xnor_out;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;
   logic [6:0]       fail_vec;
   logic [1:0]       first_fail_idx;
   logic             first_fail_vld;

   modport master (
      output start, and_out, or_out, not_out, nand_out, nor_out, xor_out, xnor_out,
      input  a, b, busy, done, pass, err_count, fail_vec, first_fail_idx, first_fail_vld
   );

   modport slave (
      input  start, and_out, or_out, not_out, nand_out, nor_out, xor_out, xnor_out,
      output a, b, busy, done, pass, err_count, fail_vec, first_fail_idx, first_fail_vld
   );
endinterface

// File: rtl/gate_truth_checker.sv
// Walks a/b through the four two-input vectors, lets the gate block settle,
// then compares its seven outputs against the ideal truth table.
module gate_truth_checker #(
   parameter int SETTLE_CYCLES = 2,
   parameter int LOOPS         = 1,
   parameter int ERR_W         = 4
) (
   input logic                clk,
   input logic                rst,
   gate_truth_checker_if.slave bus
);
   localparam int CNT_W  = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int LOOP_W = (LOOPS > 2) ? $clog2(LOOPS) : 1;
   localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   localparam logic [LOOP_W-1:0] LAST_LOOP = LOOP_W'(LOOPS - 1);
   localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRIVE  = 3'd1,
      S_SETTLE = 3'd2,
      S_CHECK  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   function automatic logic [2:0] popcount7(input logic [6:0] v);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 7; i++) begin
         n = n + {2'b00, v[i]};
      end
      return n;
   endfunction

   function automatic logic [6:0] gate_expect(input logic a, input logic b);
      return {a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
   endfunction

   function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc, input logic [2:0] inc);
      logic [ERR_W+2:0] sum;
      sum = {3'b000, acc} + {{ERR_W{1'b0}}, inc};
      if (sum > {3'b000, ERR_MAX}) begin
         return ERR_MAX;
      end else begin
         return sum[ERR_W-1:0];
      end
   endfunction

   state_t            state_q, state_d;
   logic [1:0]        ab_q, ab_d;
   logic [LOOP_W-1:0] loop_q, loop_d;
   logic [CNT_W-1:0]  wait_q, wait_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [ERR_W-1:0]  err_count_q, err_count_d;
   logic [6:0]        fail_vec_q, fail_vec_d;
   logic [1:0]        ffi_q, ffi_d;
   logic              ffv_q, ffv_d;

   logic [6:0]        resp_s;
   logic [6:0]        mism_s;
   logic [ERR_W-1:0]  err_next_s;

   assign resp_s     = {bus.and_out, bus.or_out, bus.not_out, bus.nand_out,
                        bus.nor_out, bus.xor_out, bus.xnor_out};
   assign mism_s     = gate_expect(ab_q[1], ab_q[0]) ^ resp_s;
   assign err_next_s = sat_add(err_count_q, popcount7(mism_s));

   // Next-state and result bookkeeping; ab_q doubles as the vector index.
   always_comb begin
      state_d     = state_q;
      ab_d        = ab_q;
      loop_d      = loop_q;
      wait_d      = wait_q;
      done_d      = 1'b0;
      pass_d      = pass_q;
      err_count_d = err_count_q;
      fail_vec_d  = fail_vec_q;
      ffi_d       = ffi_q;
      ffv_d       = ffv_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d     = S_DRIVE;
               ab_d        = 2'b00;
               loop_d      = '0;
               pass_d      = 1'b0;
               err_count_d = '0;
               fail_vec_d  = 7'b0000000;
               ffi_d       = 2'b00;
               ffv_d       = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DRIVE: begin
            if (SETTLE_CYCLES > 0) begin
               state_d = S_SETTLE;
               wait_d  = WAIT_INIT;
            end else begin
               state_d = S_CHECK;
            end
         end
         S_SETTLE: begin
            if (wait_q == '0) begin
               state_d = S_CHECK;
            end else begin
               wait_d = wait_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         S_CHECK: begin
            err_count_d = err_next_s;
            fail_vec_d  = fail_vec_q | mism_s;
            if ((mism_s != 7'b0000000) && !ffv_q) begin
               ffi_d = ab_q;
               ffv_d = 1'b1;
            end else begin
               ffv_d = ffv_q;
            end
            if ((ab_q == 2'b11) && (loop_q == LAST_LOOP)) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               pass_d  = (err_next_s == '0);
            end else begin
               state_d = S_DRIVE;
               ab_d    = ab_q + 2'b01;
               if (ab_q == 2'b11) begin
                  loop_d = loop_q + {{(LOOP_W-1){1'b0}}, 1'b1};
               end else begin
                  loop_d = loop_q;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            ab_d    = 2'b00;
         end
         default: begin
            state_d = S_IDLE;
            ab_d    = 2'b00;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ab_q        <= 2'b00;
         loop_q      <= '0;
         wait_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_count_q <= '0;
         fail_vec_q  <= 7'b0000000;
         ffi_q       <= 2'b00;
         ffv_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ab_q        <= ab_d;
         loop_q      <= loop_d;
         wait_q      <= wait_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_count_q <= err_count_d;
         fail_vec_q  <= fail_vec_d;
         ffi_q       <= ffi_d;
         ffv_q       <= ffv_d;
      end
   end

   assign bus.a              = ab_q[1];
   assign bus.b              = ab_q[0];
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.pass           = pass_q;
   assign bus.err_count      = err_count_q;
   assign bus.fail_vec       = fail_vec_q;
   assign bus.first_fail_idx = ffi_q;
   assign bus.first_fail_vld = ffv_q;
endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench: three checker instances (defaults, LOOPS=2, SETTLE_CYCLES=0)
// around a gate model with selectable faults; a monitor pops expectations on done.
module tb_gate_truth_checker;
   logic clk;
   logic rst;
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;
   int   fault_def = 0;
   int   fault_l2  = 0;
   int   fault_s0  = 0;

   typedef struct {
      logic       pass;
      logic [3:0] err;
      logic [6:0] fv;
      logic [1:0] ffi;
      logic       ffv;
      int         done_cyc;
   } exp_t;

   exp_t q_def[$];
   exp_t q_l2[$];
   exp_t q_s0[$];
   exp_t e_def, e_l2, e_s0;

   gate_truth_checker_if #(.ERR_W(4)) if_def ();
   gate_truth_checker_if #(.ERR_W(4)) if_l2 ();
   gate_truth_checker_if #(.ERR_W(4)) if_s0 ();

   gate_truth_checker #(.SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(4)) u_def (.clk(clk), .rst(rst), .bus(if_def.slave));
   gate_truth_checker #(.SETTLE_CYCLES(2), .LOOPS(2), .ERR_W(4)) u_l2  (.clk(clk), .rst(rst), .bus(if_l2.slave));
   gate_truth_checker #(.SETTLE_CYCLES(0), .LOOPS(1), .ERR_W(4)) u_s0  (.clk(clk), .rst(rst), .bus(if_s0.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in gate block: fault 1 = and stuck at 0, fault 2 = xor/xnor swapped.
   function automatic logic [6:0] gate_model(input logic a, input logic b, input int fault);
      logic [6:0] r;
      r = {a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
      if (fault == 1) r[6] = 1'b0;
      if (fault == 2) r[1:0] = {r[0], r[1]};
      return r;
   endfunction

   assign {if_def.and_out, if_def.or_out, if_def.not_out, if_def.nand_out, if_def.nor_out,
           if_def.xor_out, if_def.xnor_out} = gate_model(if_def.a, if_def.b, fault_def);
   assign {if_l2.and_out, if_l2.or_out, if_l2.not_out, if_l2.nand_out, if_l2.nor_out,
           if_l2.xor_out, if_l2.xnor_out} = gate_model(if_l2.a, if_l2.b, fault_l2);
   assign {if_s0.and_out, if_s0.or_out, if_s0.not_out, if_s0.nand_out, if_s0.nor_out,
           if_s0.xor_out, if_s0.xnor_out} = gate_model(if_s0.a, if_s0.b, fault_s0);

   task automatic cmp(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic score(input string inst, input exp_t e, input logic pass, input logic [3:0] err,
                        input logic [6:0] fv, input logic [1:0] ffi, input logic ffv);
      cmp({inst, "_done_cycle"}, cyc, e.done_cyc);
      cmp({inst, "_pass"}, int'(pass), int'(e.pass));
      cmp({inst, "_err_count"}, int'(err), int'(e.err));
      cmp({inst, "_fail_vec"}, int'(fv), int'(e.fv));
      cmp({inst, "_first_fail_vld"}, int'(ffv), int'(e.ffv));
      if (e.ffv) cmp({inst, "_first_fail_idx"}, int'(ffi), int'(e.ffi));
   endtask

   // Monitors: every done pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (if_def.done) begin
         if (q_def.size() == 0) cmp("def_unexpected_done", 1, 0);
         else begin
            e_def = q_def.pop_front();
            score("def", e_def, if_def.pass, if_def.err_count, if_def.fail_vec, if_def.first_fail_idx, if_def.first_fail_vld);
         end
      end
      if (if_l2.done) begin
         if (q_l2.size() == 0) cmp("l2_unexpected_done", 1, 0);
         else begin
            e_l2 = q_l2.pop_front();
            score("l2", e_l2, if_l2.pass, if_l2.err_count, if_l2.fail_vec, if_l2.first_fail_idx, if_l2.first_fail_vld);
         end
      end
      if (if_s0.done) begin
         if (q_s0.size() == 0) cmp("s0_unexpected_done", 1, 0);
         else begin
            e_s0 = q_s0.pop_front();
            score("s0", e_s0, if_s0.pass, if_s0.err_count, if_s0.fail_vec, if_s0.first_fail_idx, if_s0.first_fail_vld);
         end
      end
   end

   function automatic exp_t mk(input int done_cyc, input logic pass, input logic [3:0] err,
                               input logic [6:0] fv, input logic [1:0] ffi, input logic ffv);
      exp_t e;
      e.done_cyc = done_cyc; e.pass = pass; e.err = err; e.fv = fv; e.ffi = ffi; e.ffv = ffv;
      return e;
   endfunction

   // One-cycle start pulse; returns at the negedge of the first DRIVE cycle.
   task automatic launch(input int which, input int lat, input logic pass, input logic [3:0] err,
                         input logic [6:0] fv, input logic [1:0] ffi, input logic ffv);
      @(negedge clk);
      case (which)
         0: begin if_def.start = 1'b1; q_def.push_back(mk(cyc + 1 + lat, pass, err, fv, ffi, ffv)); end
         1: begin if_l2.start  = 1'b1; q_l2.push_back(mk(cyc + 1 + lat, pass, err, fv, ffi, ffv)); end
         default: begin if_s0.start = 1'b1; q_s0.push_back(mk(cyc + 1 + lat, pass, err, fv, ffi, ffv)); end
      endcase
      @(negedge clk);
      if_def.start = 1'b0;
      if_l2.start  = 1'b0;
      if_s0.start  = 1'b0;
   endtask

   task automatic drain(input string name, input int budget);
      int pending;
      for (int i = 0; i < budget; i++) begin
         pending = q_def.size() + q_l2.size() + q_s0.size();
         if (pending == 0) break;
         @(negedge clk);
      end
      cmp({name, "_pending_after_budget"}, q_def.size() + q_l2.size() + q_s0.size(), 0);
   endtask

   task automatic wait_cyc(input int target);
      for (int i = 0; i < 400; i++) begin
         if (cyc == target) break;
         @(negedge clk);
      end
      cmp("wait_cycle_reached", cyc, target);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      int nb;
      rst = 1'b1;
      if_def.start = 1'b0;
      if_l2.start  = 1'b0;
      if_s0.start  = 1'b0;
      repeat (3) @(negedge clk);
      cmp("reset_def", int'({if_def.a, if_def.b, if_def.busy, if_def.done, if_def.pass, if_def.err_count,
                             if_def.fail_vec, if_def.first_fail_idx, if_def.first_fail_vld}), 0);
      cmp("reset_l2", int'({if_l2.a, if_l2.b, if_l2.busy, if_l2.done, if_l2.pass, if_l2.err_count,
                            if_l2.fail_vec, if_l2.first_fail_idx, if_l2.first_fail_vld}), 0);
      cmp("reset_s0", int'({if_s0.a, if_s0.b, if_s0.busy, if_s0.done, if_s0.pass, if_s0.err_count,
                            if_s0.fail_vec, if_s0.first_fail_idx, if_s0.first_fail_vld}), 0);
      rst = 1'b0;

      // Test 1: clean gates, vector trace 00,01,10,11 at four cycles each.
      launch(0, 16, 1'b1, 4'd0, 7'b0000000, 2'b00, 1'b0);
      for (int k = 1; k <= 18; k++) begin
         cmp($sformatf("t1_ab_k%0d", k), int'({if_def.a, if_def.b}), (k <= 16) ? (k - 1) / 4 : ((k == 17) ? 3 : 0));
         cmp($sformatf("t1_busy_k%0d", k), int'(if_def.busy), (k <= 17) ? 1 : 0);
         @(negedge clk);
      end
      drain("t1", 10);
      repeat (3) @(negedge clk);
      cmp("t1_pass_held", int'(if_def.pass), 1);

      // Test 2: and stuck at 0; start pulses mid-run and in DONE are ignored.
      fault_def = 1;
      launch(0, 16, 1'b0, 4'd1, 7'b1000000, 2'b11, 1'b1);
      e0 = cyc;
      repeat (4) @(negedge clk);
      if_def.start = 1'b1;
      @(negedge clk);
      if_def.start = 1'b0;
      wait_cyc(e0 + 16);
      cmp("t2_done_cycle_seen", int'(if_def.done), 1);
      if_def.start = 1'b1;
      @(negedge clk);
      if_def.start = 1'b0;
      repeat (20) @(negedge clk);
      drain("t2", 5);
      cmp("t2_idle_after", int'(if_def.busy), 0);
      cmp("t2_err_held", int'(if_def.err_count), 1);
      cmp("t2_pass_held", int'(if_def.pass), 0);

      // Test 4: start held high -> two back-to-back runs, counters cleared.
      @(negedge clk);
      if_def.start = 1'b1;
      q_def.push_back(mk(cyc + 17, 1'b0, 4'd1, 7'b1000000, 2'b11, 1'b1));
      q_def.push_back(mk(cyc + 35, 1'b0, 4'd1, 7'b1000000, 2'b11, 1'b1));
      nb = 0;
      for (int k = 0; k <= 17; k++) begin
         @(negedge clk);
         if (if_def.busy) nb++;
      end
      cmp("t4_idle_gap_busy", int'(if_def.busy), 0);
      cmp("t4_busy_cycles", nb, 17);
      @(negedge clk);
      if_def.start = 1'b0;
      drain("t4", 30);

      // Test 5: reset during SETTLE of vector 10 discards the run.
      fault_def = 2;
      @(negedge clk);
      if_def.start = 1'b1;
      @(negedge clk);
      if_def.start = 1'b0;
      e0 = cyc;
      wait_cyc(e0 + 9);
      cmp("t5_ab_before_rst", int'({if_def.a, if_def.b}), 2);
      cmp("t5_err_before_rst", int'(if_def.err_count), 4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cmp("t5_busy_after_rst", int'(if_def.busy), 0);
      cmp("t5_ab_after_rst", int'({if_def.a, if_def.b}), 0);
      cmp("t5_err_after_rst", int'(if_def.err_count), 0);
      cmp("t5_fv_after_rst", int'(if_def.fail_vec), 0);
      repeat (25) @(negedge clk);
      fault_def = 0;
      launch(0, 16, 1'b1, 4'd0, 7'b0000000, 2'b00, 1'b0);
      drain("t5", 25);

      // Test 3: LOOPS=2, xor/xnor swapped -> 16 bad bits saturate at 15.
      fault_l2 = 2;
      launch(1, 32, 1'b0, 4'd15, 7'b0000011, 2'b00, 1'b1);
      drain("t3", 40);

      // Test 6: SETTLE_CYCLES=0 -> two cycles per vector.
      launch(2, 8, 1'b1, 4'd0, 7'b0000000, 2'b00, 1'b0);
      for (int k = 1; k <= 9; k++) begin
         cmp($sformatf("t6_ab_k%0d", k), int'({if_s0.a, if_s0.b}), (k <= 8) ? (k - 1) / 2 : 3);
         @(negedge clk);
      end
      drain("t6", 10);
      fault_s0 = 1;
      launch(2, 8, 1'b0, 4'd1, 7'b1000000, 2'b11, 1'b1);
      drain("t6b", 15);

      repeat (3) @(negedge clk);
      cmp("final_queues_empty", q_def.size() + q_l2.size() + q_s0.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
